// File: rtl/addsub_pkg.sv
// Shared opcode encodings and opcode decode for the pipelined adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } op_t;

    typedef struct packed {
        logic inv;
        logic c0;
    } op_ctl_t;

    // Every op reduces to A + (B ^ {inv}) + c0.
    function automatic op_ctl_t decode_op(op_t op, logic cin);
        op_ctl_t ctl;
        ctl.inv = 1'b0;
        ctl.c0  = 1'b0;
        case (op)
            OP_ADD: begin ctl.inv = 1'b0; ctl.c0 = 1'b0; end
            OP_SUB: begin ctl.inv = 1'b1; ctl.c0 = 1'b1; end
            OP_ADC: begin ctl.inv = 1'b0; ctl.c0 = cin;  end
            OP_SBC: begin ctl.inv = 1'b1; ctl.c0 = cin;  end
            default: begin ctl.inv = 1'b0; ctl.c0 = 1'b0; end
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/csla_segment.sv
// One carry-select segment: both carry-in candidates computed, then muxed on ci.
module csla_segment #(
    parameter int unsigned SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb_in
);

    logic [SEG:0] sum0;
    logic [SEG:0] sum1;

    assign sum0 = {1'b0, a} + {1'b0, b};
    assign sum1 = {1'b0, a} + {1'b0, b} + (SEG+1)'(1);
    assign {co, s} = ci ? sum1 : sum0;
    // Carry into the top bit recovered from the sum bit and its operands.
    assign c_msb_in = s[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined carry-select add/sub with ADC/SBC, NZCV flags and valid/ready backpressure.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_n,
    output logic             out_z,
    output logic             out_c,
    output logic             out_v
);

    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    logic    adv_c;
    op_ctl_t ctl_c;

    logic [STAGES-1:0][WIDTH-1:0] a_d, a_q, b_d, b_q, s_d, s_q;
    logic [STAGES-1:0]            c_d, c_q, vld_d, vld_q, cm_c;
    logic                         z_d, z_q, v_d, v_q;
    logic                         unused_ok;

    assign adv_c    = ~vld_q[LAST] | out_ready;
    assign in_ready = adv_c;
    assign ctl_c    = decode_op(op_t'(in_op), in_cin);

    // Stage k consumes the low SEG bits of its operands and passes the rest down shifted.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_in, b_in, s_in, s_ins;
        logic [SEG-1:0]   seg_s;
        logic             ci, seg_co, seg_cm, vin;

        if (k == 0) begin : g_first
            assign a_in = in_a;
            assign b_in = in_b ^ {WIDTH{ctl_c.inv}};
            assign s_in = '0;
            assign ci   = ctl_c.c0;
            assign vin  = in_valid & adv_c;
        end else begin : g_next
            assign a_in = a_q[k-1];
            assign b_in = b_q[k-1];
            assign s_in = s_q[k-1];
            assign ci   = c_q[k-1];
            assign vin  = vld_q[k-1];
        end

        csla_segment #(.SEG(SEG)) u_seg (
            .a        (a_in[SEG-1:0]),
            .b        (b_in[SEG-1:0]),
            .ci       (ci),
            .s        (seg_s),
            .co       (seg_co),
            .c_msb_in (seg_cm)
        );

        always_comb begin
            s_ins = s_in;
            s_ins[k*SEG +: SEG] = seg_s;
        end

        assign a_d[k]   = a_in >> SEG;
        assign b_d[k]   = b_in >> SEG;
        assign s_d[k]   = s_ins;
        assign c_d[k]   = seg_co;
        assign cm_c[k]  = seg_cm;
        assign vld_d[k] = vin;
    end

    always_comb begin
        z_d = ~|s_d[LAST];
        v_d = cm_c[LAST] ^ c_d[LAST];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            vld_q <= '0;
            z_q   <= 1'b0;
            v_q   <= 1'b0;
        end else if (adv_c) begin
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            c_q   <= c_d;
            vld_q <= vld_d;
            z_q   <= z_d;
            v_q   <= v_d;
        end
    end

    assign out_valid = vld_q[LAST];
    assign out_sum   = s_q[LAST];
    assign out_n     = s_q[LAST][WIDTH-1];
    assign out_z     = z_q;
    assign out_c     = c_q[LAST];
    assign out_v     = v_q;

    // Last-stage operand copies and inner segment MSB carries have no consumer.
    assign unused_ok = ^{a_q[LAST], b_q[LAST], cm_c};

endmodule

// File: tb/tb_pipelined_addsub.sv
// Randomized scoreboard bench for pipelined_addsub (WIDTH=32, STAGES=4).
module tb_pipelined_addsub;
    import addsub_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned ST = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_cin;
    logic [1:0]    in_op;
    logic [W-1:0]  in_a, in_b;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_sum;
    logic          out_n, out_z, out_c, out_v;

    pipelined_addsub #(.WIDTH(W), .STAGES(ST)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_n(out_n), .out_z(out_z), .out_c(out_c), .out_v(out_v)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic [3:0]   nzcv;
        int unsigned  acc_cyc;
        bit           lit;
        logic [W-1:0] lsum;
        logic [3:0]   lnzcv;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    bit          stall_seen = 1'b0;
    bit          held_v = 1'b0;
    logic [35:0] held;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: plain wide unsigned sum for result/carry, signed range test for overflow.
    function automatic exp_t ref_model(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b, logic cin);
        exp_t   e;
        logic [W:0] full;
        longint sa, sb, sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        full = '0;
        sr = 0;
        case (op)
            OP_ADD: begin full = {1'b0, a} + {1'b0, b};                sr = sa + sb; end
            OP_SUB: begin full = {1'b0, a} + {1'b0, ~b} + 33'd1;       sr = sa - sb; end
            OP_ADC: begin full = {1'b0, a} + {1'b0, b} + 33'(cin);     sr = sa + sb + longint'(cin); end
            default: begin full = {1'b0, a} + {1'b0, ~b} + 33'(cin);   sr = sa - sb - 1 + longint'(cin); end
        endcase
        e.sum   = full[W-1:0];
        e.nzcv  = {full[W-1], full[W-1:0] == '0, full[W],
                   (sr > 64'sd2147483647) || (sr < -64'sd2147483648)};
        e.acc_cyc = 0;
        e.lit   = 1'b0;
        e.lsum  = '0;
        e.lnzcv = '0;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_data();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    // One clock: drive at negedge, then evaluate what the next posedge will transfer.
    task automatic step(output bit acc, input bit iv, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input bit ordy, input bit lit = 1'b0,
                        input logic [W-1:0] lsum = '0, input logic [3:0] lnzcv = '0);
        exp_t e, h;
        @(negedge clk);
        cyc++;
        in_valid  = iv;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        out_ready = ordy;
        #1;
        chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
        if (held_v) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'({out_sum, out_n, out_z, out_c, out_v}), 64'(held));
        end
        held_v = 1'b0;
        if (out_valid) begin
            if (!out_ready) begin
                held_v = 1'b1;
                held = {out_sum, out_n, out_z, out_c, out_v};
                stall_seen = 1'b1;
            end else if (q.size() == 0) begin
                chk("spurious_out", 64'd1, 64'd0);
            end else begin
                h = q.pop_front();
                chk("sum", 64'(out_sum), 64'(h.sum));
                chk("nzcv", 64'({out_n, out_z, out_c, out_v}), 64'(h.nzcv));
                if (h.lit) begin
                    chk("lit_sum", 64'(out_sum), 64'(h.lsum));
                    chk("lit_nzcv", 64'({out_n, out_z, out_c, out_v}), 64'(h.lnzcv));
                end
                if (!stall_seen) chk("latency", 64'(cyc - h.acc_cyc), 64'(ST));
            end
        end
        acc = iv && in_ready;
        if (acc) begin
            e = ref_model(op, a, b, cin);
            e.acc_cyc = cyc;
            e.lit   = lit;
            e.lsum  = lsum;
            e.lnzcv = lnzcv;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            step(acc, 1'b0, 2'b00, '0, '0, 1'b0, 1'b1);
            n++;
        end
        chk("drain_left", 64'(q.size()), 64'd0);
        for (int i = 0; i < 6; i++) step(acc, 1'b0, 2'b00, '0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           acc;
        bit           p_v;
        logic [1:0]   p_op;
        logic [W-1:0] p_a, p_b;
        logic         p_cin;

        rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0;
        in_cin = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_flags", 64'({out_n, out_z, out_c, out_v}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed spec vectors, including 64-bit add and subtract chains.
        stall_seen = 1'b0;
        step(acc, 1'b1, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 4'b1001);
        step(acc, 1'b1, OP_SUB, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 4'b0110);
        step(acc, 1'b1, OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'b1000);
        step(acc, 1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 4'b0110);
        step(acc, 1'b1, OP_ADC, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0002, 4'b0000);
        step(acc, 1'b1, OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'b1000);
        step(acc, 1'b1, OP_SBC, 32'h0000_0005, 32'h0000_0002, 1'b0, 1'b1, 1'b1, 32'h0000_0002, 4'b0010);
        drain();

        // Eight back-to-back beats at full throughput.
        stall_seen = 1'b0;
        for (int i = 0; i < 8; i++)
            step(acc, 1'b1, 2'($urandom), rnd_data(), rnd_data(), 1'($urandom), 1'b1);
        drain();

        // Full pipe, then out_ready low for five cycles with a beat held at the input.
        p_op = OP_ADC; p_a = rnd_data(); p_b = rnd_data(); p_cin = 1'b1;
        for (int i = 0; i < 6; i++)
            step(acc, 1'b1, 2'($urandom), rnd_data(), rnd_data(), 1'($urandom), 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(acc, 1'b1, p_op, p_a, p_b, p_cin, 1'b0);
            chk("stall_no_accept", 64'(acc), 64'd0);
        end
        step(acc, 1'b1, p_op, p_a, p_b, p_cin, 1'b1);
        chk("release_accept", 64'(acc), 64'd1);
        drain();

        // Random traffic with random backpressure; unaccepted beats are held.
        p_v = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!p_v) begin
                p_v   = ($urandom_range(0, 9) < 7);
                p_op  = 2'($urandom);
                p_a   = rnd_data();
                p_b   = rnd_data();
                p_cin = 1'($urandom);
            end
            step(acc, p_v, p_op, p_a, p_b, p_cin, $urandom_range(0, 3) != 0);
            if (acc) p_v = 1'b0;
        end
        drain();

        // Reset with three beats in flight and the head beat stalled at the output.
        for (int i = 0; i < 3; i++)
            step(acc, 1'b1, OP_ADD, rnd_data(), rnd_data(), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++)
            step(acc, 1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_sum", 64'(out_sum), 64'd0);
        chk("midrst_flags", 64'({out_n, out_z, out_c, out_v}), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        held_v = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        stall_seen = 1'b0;
        step(acc, 1'b1, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 4'b1001);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
